reset_seq: RTL and testbench
============================

# reset_seq

Board-level reset sequencer for the PicoRV SoC. It merges three reset sources into a staged pair of active-low reset outputs: the synchronous system reset, a debounced user button, and a CPU soft-reset request. Peripherals are released first and the CPU a fixed gap later. It sits between the board reset/button pins and every reset consumer in the SoC, including downstream reset-delay stages.

## Interface
- `HOLD_CYCLES`, default 65535: cycles both outputs stay asserted after the last reset event (≥1).
- `GAP_CYCLES`, default 16: cycles between peripheral release and CPU release (≥1).
- `DEB_CYCLES`, default 255: consecutive stable samples required to accept a button level change (≥1).
- `clk_i`, in, 1: single system clock.
- `rst_i`, in, 1: reset, synchronous, active-low.
- `btn_ni`, in, 1: raw user button, active-low, asynchronous to `clk_i`, bouncy.
- `soft_req_i`, in, 1: CPU soft-reset request, one-cycle pulse, synchronous.
- `periph_rstn_o`, out, 1: peripheral reset, active-low, registered.
- `cpu_rstn_o`, out, 1: CPU reset, active-low, registered.
- `busy_o`, out, 1: high whenever the FSM is not in RUN.
- `cause_o`, out, 2: source of the last reset. 0 = `rst_i`, 1 = button, 2 = soft. 3 is never driven.

## Operation
- **Reset** (`rst_i`=0 at an edge): state=HOLD, counter=0, `periph_rstn_o`=0, `cpu_rstn_o`=0, `busy_o`=1, `cause_o`=0. Both sync flops=1, `btn_clean`=1, debounce counter=0.
- **Button path:**
  - 2-flop synchronizer produces `s2`.
  - Debounce counter increments on each edge where `s2`≠`btn_clean` and clears on any edge where they are equal.
  - On the edge the counter reaches `DEB_CYCLES`, `btn_clean` takes `s2` and the counter clears.
  - A press event is `btn_clean` 1→0, registered as a one-cycle `press` flag.
- **FSM states:** HOLD, GAP, RUN.
  - HOLD: both outputs 0. The counter increments each edge. It is held at 0 while `btn_clean`=0. At counter==`HOLD_CYCLES`-1 → GAP, counter=0, `periph_rstn_o`←1.
  - GAP: `periph_rstn_o`=1, `cpu_rstn_o`=0. At counter==`GAP_CYCLES`-1 → RUN, `cpu_rstn_o`←1.
  - RUN: both outputs 1. The FSM stays in RUN until an event occurs.
- **Event handling:** an event is `press` or `soft_req_i`. In any state it forces HOLD, counter=0, and both outputs←0 on the same edge.
  - A restart from HOLD or GAP reasserts `periph_rstn_o` if needed.
  - `cause_o` is updated on every event.
  - If `press` and `soft_req_i` occur on the same edge, `cause_o`=1.
- **Priority:** `rst_i` overrides everything, then button, then soft request.
- Counter width is `$clog2(max(HOLD_CYCLES,GAP_CYCLES)+1)`. The counter never wraps, because it clears on every state change.

## Timing
- Edge numbering: edge 1 is the first rising edge sampling `rst_i`=1, or the first edge after an event edge.
  - `periph_rstn_o` rises at edge `HOLD_CYCLES`.
  - `cpu_rstn_o` and `busy_o`↓ change at edge `HOLD_CYCLES`+`GAP_CYCLES`.
- **Soft request:** `soft_req_i` sampled high at edge E drives outputs low at edge E.
- **Button press latency:** `btn_ni` falls before edge 1 and stays low.
  - `s2`=0 at edge 2.
  - `btn_clean`=0 at edge `DEB_CYCLES`+2.
  - `press` is set and outputs go low at edge `DEB_CYCLES`+3.
- **Button release:** `btn_clean` returns to 1 at `DEB_CYCLES`+2 edges after release. The HOLD count then starts, and `periph_rstn_o` rises `HOLD_CYCLES` edges after that.
- **Glitch rejection:** a glitch shorter than `DEB_CYCLES` samples never changes `btn_clean`.
- **Reset mid-operation:** `rst_i`=0 in any state applies the reset values at that edge.

## Test plan
All scenarios use `HOLD_CYCLES`=8, `GAP_CYCLES`=4, `DEB_CYCLES`=4.
1. Hold `rst_i`=0 for 3 cycles, then release.
   - While in reset: outputs 0, `busy_o`=1, `cause_o`=0.
   - `periph_rstn_o`↑ at edge 8; `cpu_rstn_o`↑ and `busy_o`↓ at edge 12.
2. In RUN, pulse `soft_req_i` at edge E.
   - Both outputs 0 at E, `cause_o`=2.
   - `periph_rstn_o`↑ at E+8, `cpu_rstn_o`↑ at E+12.
3. Drive `btn_ni` low for 20 cycles in RUN.
   - Outputs 0 at edge 7 after the fall, `cause_o`=1.
   - Outputs held low while pressed.
   - `periph_rstn_o`↑ 8 edges after `btn_clean` returns to 1.
4. Drive `btn_ni` low for 3 cycles, then bounce it 1/0 every 2 cycles for 20 cycles.
   - Outputs never drop; `cause_o` unchanged.
5. Pulse `soft_req_i` during GAP (edge 10 after release).
   - `periph_rstn_o`↓ at edge 10; `cpu_rstn_o` stays 0.
   - `periph_rstn_o`↑ at edge 18, `cpu_rstn_o`↑ at edge 22.
6. In RUN, assert `soft_req_i` on the same edge `press` fires → `cause_o`=1.
   - Then drive `rst_i`=0 for one edge → outputs 0 and `cause_o`=0 at that edge, and the sequence restarts.

Source files
------------

// File: rtl/reset_seq_if.sv
// Reset sequencer signal bundle: board/CPU reset requests in, staged resets and status out.
interface reset_seq_if;
    logic       btn_ni;
    logic       soft_req_i;
    logic       periph_rstn_o;
    logic       cpu_rstn_o;
    logic       busy_o;
    logic [1:0] cause_o;

    // SoC / board side: drives requests, observes staged resets.
    modport master (
        output btn_ni,
        output soft_req_i,
        input  periph_rstn_o,
        input  cpu_rstn_o,
        input  busy_o,
        input  cause_o
    );

    // Sequencer side.
    modport slave (
        input  btn_ni,
        input  soft_req_i,
        output periph_rstn_o,
        output cpu_rstn_o,
        output busy_o,
        output cause_o
    );
endinterface

// File: rtl/reset_seq.sv
// Board-level reset sequencer: merges system reset, debounced button and CPU
// soft-reset into a staged peripheral-then-CPU active-low reset release.
module reset_seq #(
    parameter int unsigned HOLD_CYCLES = 65535,
    parameter int unsigned GAP_CYCLES  = 16,
    parameter int unsigned DEB_CYCLES  = 255
) (
    input logic        clk_i,
    input logic        rst_i,
    reset_seq_if.slave bus
);

    localparam int unsigned MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam int unsigned DEB_W   = $clog2(DEB_CYCLES + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);

    localparam logic [1:0] CAUSE_RST  = 2'd0;
    localparam logic [1:0] CAUSE_BTN  = 2'd1;
    localparam logic [1:0] CAUSE_SOFT = 2'd2;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_GAP  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    logic             btn_s1;
    logic             btn_s2;
    logic             btn_clean;
    logic [DEB_W-1:0] deb_cnt;
    logic             press;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             periph_rstn_q;
    logic             cpu_rstn_q;
    logic             busy_q;
    logic [1:0]       cause_q;

    logic             evt_c;

    // Button synchronizer and debouncer; press is a one-cycle flag on the 1->0 accept.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            btn_s1    <= 1'b1;
            btn_s2    <= 1'b1;
            btn_clean <= 1'b1;
            deb_cnt   <= '0;
            press     <= 1'b0;
        end else begin
            btn_s1 <= bus.btn_ni;
            btn_s2 <= btn_s1;
            press  <= 1'b0;
            if (btn_s2 == btn_clean) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                btn_clean <= btn_s2;
                deb_cnt   <= '0;
                press     <= btn_clean;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    // A button press or soft request restarts the sequence from any state.
    always_comb begin
        evt_c = press | bus.soft_req_i;
    end

    // Sequencer FSM: HOLD both resets, release peripherals, then CPU after the gap.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state         <= ST_HOLD;
            cnt           <= '0;
            periph_rstn_q <= 1'b0;
            cpu_rstn_q    <= 1'b0;
            busy_q        <= 1'b1;
            cause_q       <= CAUSE_RST;
        end else if (evt_c) begin
            state         <= ST_HOLD;
            cnt           <= '0;
            periph_rstn_q <= 1'b0;
            cpu_rstn_q    <= 1'b0;
            busy_q        <= 1'b1;
            cause_q       <= press ? CAUSE_BTN : CAUSE_SOFT;
        end else begin
            case (state)
                ST_HOLD: begin
                    // Count only once the button is released.
                    if (!btn_clean) begin
                        cnt <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        state         <= ST_GAP;
                        cnt           <= '0;
                        periph_rstn_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        state      <= ST_RUN;
                        cnt        <= '0;
                        cpu_rstn_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    cnt <= '0;
                end
                default: begin
                    state         <= ST_HOLD;
                    cnt           <= '0;
                    periph_rstn_q <= 1'b0;
                    cpu_rstn_q    <= 1'b0;
                    busy_q        <= 1'b1;
                end
            endcase
        end
    end

    assign bus.periph_rstn_o = periph_rstn_q;
    assign bus.cpu_rstn_o    = cpu_rstn_q;
    assign bus.busy_o        = busy_q;
    assign bus.cause_o       = cause_q;

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq with HOLD=8, GAP=4, DEB=4.
module tb_reset_seq;

    logic clk_i;
    logic rst_i;
    int   total;
    int   bad;

    reset_seq_if bus ();

    reset_seq #(
        .HOLD_CYCLES (8),
        .GAP_CYCLES  (4),
        .DEB_CYCLES  (4)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Advance n rising edges, ending 1 unit after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Compare {periph, cpu, busy, cause} against expected values.
    task automatic chk(input string tag, input logic p, input logic c,
                       input logic b, input logic [1:0] cs);
        logic [4:0] obs;
        logic [4:0] exp;
        obs = {bus.periph_rstn_o, bus.cpu_rstn_o, bus.busy_o, bus.cause_o};
        exp = {p, c, b, cs};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed{p,c,b,cause}=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Directed scenario sequence.
    initial begin
        total          = 0;
        bad            = 0;
        rst_i          = 1'b0;
        bus.btn_ni     = 1'b1;
        bus.soft_req_i = 1'b0;

        // 1: power-on reset and staged release.
        step(3);
        chk("por_in_reset", 1'b0, 1'b0, 1'b1, 2'd0);
        rst_i = 1'b1;
        step(7);
        chk("por_e7", 1'b0, 1'b0, 1'b1, 2'd0);
        step(1);
        chk("por_e8_periph", 1'b1, 1'b0, 1'b1, 2'd0);
        step(3);
        chk("por_e11_gap", 1'b1, 1'b0, 1'b1, 2'd0);
        step(1);
        chk("por_e12_run", 1'b1, 1'b1, 1'b0, 2'd0);

        // 2: soft request in RUN.
        bus.soft_req_i = 1'b1;
        step(1);
        chk("soft_e", 1'b0, 1'b0, 1'b1, 2'd2);
        bus.soft_req_i = 1'b0;
        step(7);
        chk("soft_e7", 1'b0, 1'b0, 1'b1, 2'd2);
        step(1);
        chk("soft_e8", 1'b1, 1'b0, 1'b1, 2'd2);
        step(4);
        chk("soft_e12", 1'b1, 1'b1, 1'b0, 2'd2);

        // 3: button held low for 20 cycles.
        bus.btn_ni = 1'b0;
        step(6);
        chk("btn_e6", 1'b1, 1'b1, 1'b0, 2'd2);
        step(1);
        chk("btn_e7_press", 1'b0, 1'b0, 1'b1, 2'd1);
        step(13);
        chk("btn_e20_held", 1'b0, 1'b0, 1'b1, 2'd1);
        bus.btn_ni = 1'b1;
        step(13);
        chk("btn_e33", 1'b0, 1'b0, 1'b1, 2'd1);
        step(1);
        chk("btn_e34_periph", 1'b1, 1'b0, 1'b1, 2'd1);
        step(4);
        chk("btn_e38_run", 1'b1, 1'b1, 1'b0, 2'd1);

        // 4: short press followed by bouncing must be rejected.
        bus.btn_ni = 1'b0;
        step(3);
        for (int i = 0; i < 10; i++) begin
            bus.btn_ni = (i % 2 == 0) ? 1'b1 : 1'b0;
            step(2);
            chk($sformatf("bounce_%0d", i), 1'b1, 1'b1, 1'b0, 2'd1);
        end
        bus.btn_ni = 1'b1;
        step(8);
        chk("bounce_settled", 1'b1, 1'b1, 1'b0, 2'd1);

        // 5: soft request during GAP.
        rst_i = 1'b0;
        step(1);
        chk("gap_reset", 1'b0, 1'b0, 1'b1, 2'd0);
        rst_i = 1'b1;
        step(9);
        chk("gap_e9", 1'b1, 1'b0, 1'b1, 2'd0);
        bus.soft_req_i = 1'b1;
        step(1);
        chk("gap_e10_soft", 1'b0, 1'b0, 1'b1, 2'd2);
        bus.soft_req_i = 1'b0;
        step(7);
        chk("gap_e17", 1'b0, 1'b0, 1'b1, 2'd2);
        step(1);
        chk("gap_e18_periph", 1'b1, 1'b0, 1'b1, 2'd2);
        step(3);
        chk("gap_e21", 1'b1, 1'b0, 1'b1, 2'd2);
        step(1);
        chk("gap_e22_run", 1'b1, 1'b1, 1'b0, 2'd2);

        // 6: simultaneous press and soft request, then mid-sequence reset.
        bus.btn_ni = 1'b0;
        step(6);
        chk("both_e6", 1'b1, 1'b1, 1'b0, 2'd2);
        bus.soft_req_i = 1'b1;
        step(1);
        chk("both_e7_cause", 1'b0, 1'b0, 1'b1, 2'd1);
        bus.soft_req_i = 1'b0;
        bus.btn_ni     = 1'b1;
        step(1);
        chk("both_e8", 1'b0, 1'b0, 1'b1, 2'd1);
        rst_i = 1'b0;
        step(1);
        chk("mid_reset", 1'b0, 1'b0, 1'b1, 2'd0);
        rst_i = 1'b1;
        step(7);
        chk("mid_e7", 1'b0, 1'b0, 1'b1, 2'd0);
        step(1);
        chk("mid_e8_periph", 1'b1, 1'b0, 1'b1, 2'd0);
        step(4);
        chk("mid_e12_run", 1'b1, 1'b1, 1'b0, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
